// File: rtl/stdp_pkg.sv
// Shared types and default widths for the two-neuron STDP scheduler and its weight-change unit.
package stdp_pkg;

    localparam int unsigned STDP_N = 32;
    localparam int unsigned STDP_Q = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELTA  = 3'd1,
        MUL    = 3'd2,
        ADD    = 3'd3,
        UPDATE = 3'd4
    } stdp_state_e;

    typedef enum logic {
        POT = 1'b0,
        DEP = 1'b1
    } stdp_event_e;

endpackage

// File: rtl/stdp_dw_unit.sv
// Weight-change datapath: one registered multiply stage, then add-intercept and clamp-at-zero.
module stdp_dw_unit
    import stdp_pkg::*;
#(
    parameter int N = STDP_N,
    parameter int Q = STDP_Q
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mul_en_i,
    input  logic         add_en_i,
    input  logic [N-1:0] m_i,
    input  logic [N-1:0] b_i,
    input  logic [Q-1:0] dt_i,
    output logic [N-1:0] dw_o
);

    logic [N-1:0]        prod_d, prod_q;
    logic [N-1:0]        dw_d, dw_q;
    logic signed [N-1:0] sum_s;

    // (m * (dt << Q)) >>> Q keeps only product bits above Q, which equal the low N bits of m * dt.
    always_comb begin
        prod_d = prod_q;
        if (mul_en_i) begin
            prod_d = m_i * {{(N-Q){1'b0}}, dt_i};
        end else begin
            prod_d = prod_q;
        end
    end

    // Intercept add; a negative line value produces no change rather than a reversed one.
    always_comb begin
        sum_s = $signed(prod_q) + $signed(b_i);
        dw_d  = dw_q;
        if (add_en_i) begin
            if (sum_s[N-1]) begin
                dw_d = {N{1'b0}};
            end else begin
                dw_d = sum_s;
            end
        end else begin
            dw_d = dw_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q <= {N{1'b0}};
            dw_q   <= {N{1'b0}};
        end else begin
            prod_q <= prod_d;
            dw_q   <= dw_d;
        end
    end

    assign dw_o = dw_q;

endmodule

// File: rtl/stdp_scheduler.sv
// Step timestamping and STDP update sequencer; owns the saturating coupling weight.
module stdp_scheduler
    import stdp_pkg::*;
#(
    parameter int N = STDP_N,
    parameter int Q = STDP_Q
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         apply,
    input  logic         enable_stdp,
    input  logic         spike_pre,
    input  logic         spike_post,
    input  logic         load_weight,
    input  logic [N-1:0] weight_init,
    input  logic [N-1:0] w_max,
    input  logic [Q-1:0] window,
    input  logic [N-1:0] m1,
    input  logic [N-1:0] b1,
    input  logic [N-1:0] m2,
    input  logic [N-1:0] b2,
    output logic         ready,
    output logic         busy,
    output logic [N-1:0] weight,
    output logic         weight_valid,
    output logic [Q-1:0] timestep,
    output logic         overrun
);

    stdp_state_e  state_d, state_q;
    stdp_event_e  ev_d, ev_q;
    logic [Q-1:0] timestep_d, timestep_q, t_pre_d, t_pre_q, t_post_d, t_post_q;
    logic [Q-1:0] dt_d, dt_q, window_d, window_q;
    logic         pre_valid_d, pre_valid_q, post_valid_d, post_valid_q;
    logic         overrun_d, overrun_q, wvalid_d, wvalid_q;
    logic         range_done_d, range_done_q, in_range_d, in_range_q;
    logic [N-1:0] weight_d, weight_q, m_d, m_q, b_d, b_q, wmax_d, wmax_q;
    logic [N-1:0] dw_s, upd_s;
    logic signed [N+1:0] w_ext_s, dw_ext_s, wmax_ext_s, sum_s;

    stdp_dw_unit #(.N(N), .Q(Q)) u_dw (
        .clk      (clk),
        .rst      (rst),
        .mul_en_i (state_q == MUL),
        .add_en_i (state_q == ADD),
        .m_i      (m_q),
        .b_i      (b_q),
        .dt_i     (dt_q),
        .dw_o     (dw_s)
    );

    // Apply the signed change with saturation to [0, w_max].
    always_comb begin
        w_ext_s    = {{2{weight_q[N-1]}}, weight_q};
        dw_ext_s   = {2'b00, dw_s};
        wmax_ext_s = {{2{wmax_q[N-1]}}, wmax_q};
        sum_s      = (ev_q == POT) ? (w_ext_s + dw_ext_s) : (w_ext_s - dw_ext_s);
        if (sum_s < 0) begin
            upd_s = {N{1'b0}};
        end else if (sum_s > wmax_ext_s) begin
            upd_s = wmax_q;
        end else begin
            upd_s = sum_s[N-1:0];
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d      = state_q;
        ev_d         = ev_q;
        timestep_d   = timestep_q;
        t_pre_d      = t_pre_q;
        t_post_d     = t_post_q;
        pre_valid_d  = pre_valid_q;
        post_valid_d = post_valid_q;
        dt_d         = dt_q;
        window_d     = window_q;
        m_d          = m_q;
        b_d          = b_q;
        wmax_d       = wmax_q;
        weight_d     = weight_q;
        wvalid_d     = 1'b0;
        range_done_d = range_done_q;
        in_range_d   = in_range_q;
        overrun_d    = overrun_q;

        if (apply && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            IDLE: begin
                if (load_weight) begin
                    weight_d = weight_init;
                end else begin
                    weight_d = weight_q;
                end
                if (apply) begin
                    timestep_d = timestep_q + {{(Q-1){1'b0}}, 1'b1};
                    if (spike_pre) begin
                        t_pre_d     = timestep_q;
                        pre_valid_d = 1'b1;
                    end else begin
                        t_pre_d     = t_pre_q;
                    end
                    if (spike_post) begin
                        t_post_d     = timestep_q;
                        post_valid_d = 1'b1;
                    end else begin
                        t_post_d     = t_post_q;
                    end
                    window_d = window;
                    wmax_d   = w_max;
                    // dt uses the timestamps as they stood before this step.
                    if (enable_stdp && spike_post && !spike_pre && pre_valid_q) begin
                        ev_d    = POT;
                        dt_d    = timestep_q - t_pre_q;
                        m_d     = m1;
                        b_d     = b1;
                        state_d = DELTA;
                    end else if (enable_stdp && spike_pre && !spike_post && post_valid_q) begin
                        ev_d    = DEP;
                        dt_d    = timestep_q - t_post_q;
                        m_d     = m2;
                        b_d     = b2;
                        state_d = DELTA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DELTA: begin
                if (!range_done_q) begin
                    range_done_d = 1'b1;
                    in_range_d   = (dt_q != {Q{1'b0}}) && (dt_q <= window_q);
                end else begin
                    range_done_d = 1'b0;
                    state_d      = in_range_q ? MUL : IDLE;
                end
            end
            MUL:     state_d = ADD;
            ADD:     state_d = UPDATE;
            UPDATE: begin
                weight_d = upd_s;
                wvalid_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any update in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ev_q         <= POT;
            timestep_q   <= {Q{1'b0}};
            t_pre_q      <= {Q{1'b0}};
            t_post_q     <= {Q{1'b0}};
            pre_valid_q  <= 1'b0;
            post_valid_q <= 1'b0;
            dt_q         <= {Q{1'b0}};
            window_q     <= {Q{1'b0}};
            m_q          <= {N{1'b0}};
            b_q          <= {N{1'b0}};
            wmax_q       <= {N{1'b0}};
            weight_q     <= {N{1'b0}};
            wvalid_q     <= 1'b0;
            range_done_q <= 1'b0;
            in_range_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ev_q         <= ev_d;
            timestep_q   <= timestep_d;
            t_pre_q      <= t_pre_d;
            t_post_q     <= t_post_d;
            pre_valid_q  <= pre_valid_d;
            post_valid_q <= post_valid_d;
            dt_q         <= dt_d;
            window_q     <= window_d;
            m_q          <= m_d;
            b_q          <= b_d;
            wmax_q       <= wmax_d;
            weight_q     <= weight_d;
            wvalid_q     <= wvalid_d;
            range_done_q <= range_done_d;
            in_range_q   <= in_range_d;
            overrun_q    <= overrun_d;
        end
    end

    assign ready        = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign weight       = weight_q;
    assign weight_valid = wvalid_q;
    assign timestep     = timestep_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_stdp_scheduler.sv
// Directed-vector bench for stdp_scheduler using Q16.16 STDP lines with hand-computed weights.
module tb_stdp_scheduler;

    localparam int N = 32;
    localparam int Q = 16;

    logic         clk;
    logic         rst, apply, enable_stdp, spike_pre, spike_post, load_weight;
    logic [N-1:0] weight_init, w_max, m1, b1, m2, b2;
    logic [Q-1:0] window;
    logic         ready, busy, weight_valid, overrun;
    logic [N-1:0] weight;
    logic [Q-1:0] timestep;
    int           n_vec = 0;
    int           n_err = 0;

    stdp_scheduler #(.N(N), .Q(Q)) dut (
        .clk(clk), .rst(rst), .apply(apply), .enable_stdp(enable_stdp),
        .spike_pre(spike_pre), .spike_post(spike_post), .load_weight(load_weight),
        .weight_init(weight_init), .w_max(w_max), .window(window),
        .m1(m1), .b1(b1), .m2(m2), .b2(b2),
        .ready(ready), .busy(busy), .weight(weight), .weight_valid(weight_valid),
        .timestep(timestep), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; apply = 1'b0; spike_pre = 1'b0; spike_post = 1'b0; load_weight = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic load(input logic [31:0] w);
        weight_init = w;
        load_weight = 1'b1;
        tick();
        load_weight = 1'b0;
    endtask

    task automatic step(input logic pre, input logic post);
        spike_pre = pre; spike_post = post; apply = 1'b1;
        tick();
        apply = 1'b0; spike_pre = 1'b0; spike_post = 1'b0;
    endtask

    task automatic advance_to(input logic [15:0] t);
        for (int i = 0; i < 64 && timestep != t; i++) step(1'b0, 1'b0);
    endtask

    // Called right after the accepting edge: pulse must appear exactly 5 edges later.
    task automatic expect_update(input string tag, input logic [31:0] exp_w);
        int first = 0;
        logic [31:0] w_at = 32'h0;
        logic rdy_at = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (weight_valid && first == 0) begin
                first = c; w_at = weight; rdy_at = ready;
            end
        end
        check_vec({tag, "_lat"}, 32'(first), 32'd5);
        check_vec({tag, "_w"}, w_at, exp_w);
        check_vec({tag, "_rdy"}, 32'(rdy_at), 32'd1);
    endtask

    initial begin
        rst = 1'b0; apply = 1'b0; enable_stdp = 1'b1; spike_pre = 1'b0; spike_post = 1'b0;
        load_weight = 1'b0; weight_init = 32'h0;
        m1 = 32'hFFFFC000; b1 = 32'h00010000; m2 = 32'hFFFFE000; b2 = 32'h00008000;
        window = 16'd8; w_max = 32'h00010000;

        do_reset();
        check_vec("rst_weight", weight, 32'h0);
        check_vec("rst_ts", 32'(timestep), 32'h0);
        check_vec("rst_ready", 32'(ready), 32'd1);
        check_vec("rst_busy", 32'(busy), 32'd0);
        check_vec("rst_ovr", 32'(overrun), 32'd0);
        load(32'h00008000);
        check_vec("load_w", weight, 32'h00008000);

        // Potentiation, dt = 3
        advance_to(16'd2); step(1'b1, 1'b0);
        advance_to(16'd5); step(1'b0, 1'b1);
        expect_update("t1", 32'h0000C000);

        // Depression, dt = 2
        do_reset(); load(32'h00008000);
        advance_to(16'd10); step(1'b0, 1'b1);
        advance_to(16'd12); step(1'b1, 1'b0);
        expect_update("t2", 32'h00004000);

        // dt = 9 exceeds window
        do_reset(); load(32'h00008000);
        step(1'b1, 1'b0);
        advance_to(16'd9); step(1'b0, 1'b1);
        tick();
        check_vec("t3_busy1", 32'(ready), 32'd0);
        begin
            int seen = 0;
            tick();
            check_vec("t3_ready2", 32'(ready), 32'd1);
            for (int c = 0; c < 5; c++) begin
                if (weight_valid) seen++;
                tick();
            end
            check_vec("t3_nopulse", 32'(seen), 32'd0);
        end
        check_vec("t3_w", weight, 32'h00008000);

        // Saturation at w_max, then simultaneous spikes
        do_reset(); load(32'h0000E666);
        step(1'b1, 1'b0);
        advance_to(16'd3); step(1'b0, 1'b1);
        expect_update("t4", 32'h00010000);
        step(1'b1, 1'b1);
        check_vec("t4_both_ready", 32'(ready), 32'd1);
        check_vec("t4_both_ts", 32'(timestep), 32'd5);
        begin
            int seen = 0;
            for (int c = 0; c < 6; c++) begin
                tick();
                if (weight_valid) seen++;
            end
            check_vec("t4_both_nopulse", 32'(seen), 32'd0);
        end
        check_vec("t4_both_w", weight, 32'h00010000);

        // Timestamp wrap-around
        do_reset(); load(32'h00008000);
        apply = 1'b1;
        repeat (16'hFFFE) tick();
        apply = 1'b0;
        check_vec("t5_ts_pre", 32'(timestep), 32'h0000FFFE);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        check_vec("t5_ts_wrap", 32'(timestep), 32'd1);
        step(1'b0, 1'b1);
        expect_update("t5", 32'h0000C000);
        check_vec("t5_ts_end", 32'(timestep), 32'd2);

        // Overrun and reset mid-update
        do_reset(); load(32'h00008000);
        step(1'b1, 1'b0);
        advance_to(16'd3);
        spike_post = 1'b1; apply = 1'b1;
        tick();
        spike_post = 1'b0;
        tick(); tick();
        apply = 1'b0;
        check_vec("t6_ovr", 32'(overrun), 32'd1);
        check_vec("t6_ts_hold", 32'(timestep), 32'd4);
        for (int i = 0; i < 20 && !ready; i++) tick();
        check_vec("t6_ready", 32'(ready), 32'd1);
        check_vec("t6_w", weight, 32'h0000C000);
        step(1'b0, 1'b1);
        tick(); tick();
        check_vec("t6_busy_mul", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_vec("t6_rst_w", weight, 32'h0);
        check_vec("t6_rst_ts", 32'(timestep), 32'h0);
        check_vec("t6_rst_ovr", 32'(overrun), 32'd0);
        check_vec("t6_rst_ready", 32'(ready), 32'd1);
        check_vec("t6_rst_busy", 32'(busy), 32'd0);
        check_vec("t6_rst_wv", 32'(weight_valid), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        step(1'b0, 1'b1);
        check_vec("t6_prevalid_clr", 32'(ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stdp_scheduler.md
# stdp_scheduler

Sequencing controller for the coupled two-neuron STDP datapath. It timestamps every accepted simulation step and records the last spike time of the presynaptic neuron (neuron 1) and the postsynaptic neuron (neuron 2). On each spike event it runs a multi-cycle, single-multiplier pipeline that computes a linear STDP weight change and applies it to the saturating synaptic weight. The weight it holds is the coupling weight fed to the converter between the neurons.

## Interface
- N, 32, data width; signed fixed point with Q fractional bits.
- Q, 16, fractional bits; also the timestamp width.
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- apply  in  1  a step is offered; accepted when `apply && ready`.
- enable_stdp  in  1  sampled at acceptance; when low, timestamps still update but the weight is untouched.
- spike_pre  in  1  neuron 1 spiked this step; sampled at acceptance.
- spike_post  in  1  neuron 2 spiked this step; sampled at acceptance.
- load_weight  in  1  synchronous; loads `weight_init` into `weight`; only honoured in IDLE.
- weight_init  in  N  initial weight.
- w_max  in  N  upper weight clamp (lower clamp is 0).
- window  in  Q  largest dt, in steps, that produces an update.
- m1, b1  in  N  potentiation line: dw = m1·dt + b1.
- m2, b2  in  N  depression line: dw = m2·dt + b2.
- ready  out  1  high only in IDLE.
- busy  out  1  high whenever not in IDLE.
- weight  out  N  current weight; 0 at reset.
- weight_valid  out  1  one-cycle pulse when `weight` is written by an update.
- timestep  out  Q  count of accepted steps; 0 at reset.
- overrun  out  1  sticky; set when `apply` is high while `ready` is low; cleared only by reset.

## Operation
- **Acceptance.** On an accepted step with timestep = T:
  - If `spike_pre`: t_pre ← T and pre_valid ← 1.
  - If `spike_post`: t_post ← T and post_valid ← 1.
  - timestep ← T+1, wrapping modulo 2^Q.
- **Event selection.** Only when `enable_stdp` is high:
  - Post-only spike with pre_valid: potentiation, dt = T − t_pre.
  - Pre-only spike with post_valid: depression, dt = T − t_post.
  - Both spikes in the same step: dt = 0, no update; timestamps still update.
  - No event: FSM stays in IDLE.
- **dt arithmetic.** dt is taken from the timestamps held before the step is accepted. Subtraction is unsigned modulo 2^Q, so wrap-around is transparent. An update only proceeds when 1 ≤ dt ≤ window.
- **FSM states.**
  - IDLE: on an event go to DELTA; otherwise stay.
  - DELTA: dt in range → MUL; otherwise → IDLE with no pulse.
  - MUL: prod = (m·(dt<<Q))>>>Q, signed, truncated to N bits.
  - ADD: dw = prod + b; if dw < 0 then dw = 0. The sign of the update comes from the event type only.
  - UPDATE: weight ± dw, saturated to [0, w_max]; pulse `weight_valid`; → IDLE.
- **Overrun.** An `apply` while busy is dropped: no timestamp or timestep change, and `overrun` is set.

## Timing
- Accept at edge k. DELTA at k+1, MUL at k+2, ADD at k+3, UPDATE at k+4.
- The new `weight` and the `weight_valid` pulse are visible after edge k+5. `ready` returns high in the same cycle.
- Out-of-range dt: back in IDLE after edge k+2.
- `load_weight` and acceptance in the same IDLE cycle: the load wins the weight; the step is still accepted.
- Reset asserted mid-update: all state clears immediately, the partial update is lost, and `weight` = 0. This includes pre_valid, post_valid, timestep, t_pre, t_post and overrun.
- Event parameters (m, b, window, w_max) are captured at acceptance. Changing them during busy has no effect on the update in flight.

## Structure
- Shared package `stdp_pkg`:
  - state enum {IDLE, DELTA, MUL, ADD, UPDATE}
  - event type {POT, DEP}
  - default N and Q
- Sub-module `stdp_dw_unit`: one registered multiplier reusing the codebase's `mult`, plus the add and clamp-at-0. It is sequenced by the scheduler FSM.

## Test plan
All values Q16.16. Setup: m1 = −0.25 (0xFFFFC000), b1 = 1.0, m2 = −0.125 (0xFFFFE000), b2 = 0.5, window = 8, w_max = 1.0, weight loaded to 0.5.

1. Pre spike at step 2, post spike at step 5 (dt = 3, dw = 0.25) → `weight` = 0x0000C000, `weight_valid` 5 cycles after the post acceptance.
2. Post spike at step 10, pre spike at step 12 (dt = 2, dw = 0.25) → `weight` = 0x00004000.
3. Pre spike at step 0, post spike at step 9 (dt = 9 > window) → no `weight_valid`; `ready` back after 2 cycles.
4. Weight 0.9, potentiation with dt = 3 → `weight` saturates to 0x00010000. Also: pre and post spike in the same step → no change.
5. Timestamp wrap: pre spike at step 0xFFFE, post spike at step 0x0001 → dt = 3, weight + 0.25.
6. `apply` held high during busy → `overrun` = 1 and `timestep` unchanged. `rst` low during MUL → all outputs 0 and `ready` = 1.
